// File: rtl/max_min_pkg.sv
// Shared constants for the max/min streaming tracker: FSM states and ranking modes.
package max_min_pkg;

  localparam int unsigned STATE_W = 1;

  // Frame collection and result-hold states
  localparam logic [STATE_W-1:0] ACC  = 1'b0;
  localparam logic [STATE_W-1:0] HOLD = 1'b1;

  // Ranking direction
  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/max_min_better.sv
// Strict "better than" comparator: greater in MODE_MAX, smaller in MODE_MIN; ties never win.
module max_min_better
  import max_min_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] cand,
  input  logic [WIDTH-1:0] ref_val,
  output logic             better
);

  assign better = (mode == MODE_MIN) ? (cand < ref_val) : (cand > ref_val);

endmodule

// File: rtl/max_min_stream.sv
// Tracks the best and second-best samples of a framed stream and presents them
// with their beat indices and a saturating beat count once the frame closes.
module max_min_stream
  import max_min_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_best1,
  output logic [WIDTH-1:0] out_best2,
  output logic [CNT_W-1:0] out_idx1,
  output logic [CNT_W-1:0] out_idx2,
  output logic [CNT_W-1:0] out_count,
  output logic             out_has2,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [STATE_W-1:0] state, state_nxt;

  logic [WIDTH-1:0] best1, best1_nxt;
  logic [WIDTH-1:0] best2, best2_nxt;
  logic [CNT_W-1:0] idx1, idx1_nxt;
  logic [CNT_W-1:0] idx2, idx2_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             has2, has2_nxt;
  logic             ovf, ovf_nxt;
  logic             mode_q, mode_nxt;

  logic beat;
  logic first;
  logic eff_mode;
  logic better1;
  logic better2;

  assign beat     = in_valid & in_ready;
  // count is never zero once a frame has a beat, so it doubles as the frame-start flag
  assign first    = (count == '0);
  assign eff_mode = first ? mode : mode_q;

  max_min_better #(.WIDTH(WIDTH)) u_cmp1 (
    .mode    (eff_mode),
    .cand    (in_data),
    .ref_val (best1),
    .better  (better1)
  );

  max_min_better #(.WIDTH(WIDTH)) u_cmp2 (
    .mode    (eff_mode),
    .cand    (in_data),
    .ref_val (best2),
    .better  (better2)
  );

  // State register plus registered handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == ACC);
      out_valid <= (state_nxt == HOLD);
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (beat && in_last) state_nxt = HOLD;
      HOLD:    if (out_ready)       state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // Tracker update: insert the beat into the two ranked slots, clear on result handoff
  always_comb begin
    best1_nxt = best1;
    best2_nxt = best2;
    idx1_nxt  = idx1;
    idx2_nxt  = idx2;
    count_nxt = count;
    has2_nxt  = has2;
    ovf_nxt   = ovf;
    mode_nxt  = mode_q;

    if (state == HOLD && out_ready) begin
      best1_nxt = '0;
      best2_nxt = '0;
      idx1_nxt  = '0;
      idx2_nxt  = '0;
      count_nxt = '0;
      has2_nxt  = 1'b0;
      ovf_nxt   = 1'b0;
      mode_nxt  = MODE_MAX;
    end else if (beat) begin
      if (count == CNT_MAX) begin
        ovf_nxt = 1'b1;
      end else begin
        count_nxt = count + CNT_W'(1);
      end

      if (first) begin
        mode_nxt  = mode;
        best1_nxt = in_data;
        idx1_nxt  = '0;
        best2_nxt = '0;
        idx2_nxt  = '0;
        has2_nxt  = 1'b0;
      end else if (better1) begin
        best2_nxt = best1;
        idx2_nxt  = idx1;
        best1_nxt = in_data;
        idx1_nxt  = count;
        has2_nxt  = 1'b1;
      end else if (!has2 || better2) begin
        best2_nxt = in_data;
        idx2_nxt  = count;
        has2_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best1  <= '0;
      best2  <= '0;
      idx1   <= '0;
      idx2   <= '0;
      count  <= '0;
      has2   <= 1'b0;
      ovf    <= 1'b0;
      mode_q <= MODE_MAX;
    end else begin
      best1  <= best1_nxt;
      best2  <= best2_nxt;
      idx1   <= idx1_nxt;
      idx2   <= idx2_nxt;
      count  <= count_nxt;
      has2   <= has2_nxt;
      ovf    <= ovf_nxt;
      mode_q <= mode_nxt;
    end
  end

  assign out_best1 = best1;
  assign out_best2 = best2;
  assign out_idx1  = idx1;
  assign out_idx2  = idx2;
  assign out_count = count;
  assign out_has2  = has2;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_max_min_stream.sv
// Directed bench for max_min_stream: default-width instance A plus a CNT_W=2 instance B
// for count saturation.
module tb_max_min_stream;

  localparam int unsigned W  = 4;
  localparam int unsigned CA = 8;
  localparam int unsigned CB = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic [W-1:0] in_data;
  logic         in_valid_a;
  logic         in_valid_b;
  logic         in_last;
  logic         out_ready;

  logic          in_ready_a, out_valid_a, out_has2_a, out_ovf_a;
  logic [W-1:0]  out_best1_a, out_best2_a;
  logic [CA-1:0] out_idx1_a, out_idx2_a, out_count_a;

  logic          in_ready_b, out_valid_b, out_has2_b, out_ovf_b;
  logic [W-1:0]  out_best1_b, out_best2_b;
  logic [CB-1:0] out_idx1_b, out_idx2_b, out_count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  max_min_stream #(.WIDTH(W), .CNT_W(CA)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid_a),
    .in_last   (in_last),
    .in_ready  (in_ready_a),
    .out_best1 (out_best1_a),
    .out_best2 (out_best2_a),
    .out_idx1  (out_idx1_a),
    .out_idx2  (out_idx2_a),
    .out_count (out_count_a),
    .out_has2  (out_has2_a),
    .out_ovf   (out_ovf_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready)
  );

  max_min_stream #(.WIDTH(W), .CNT_W(CB)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid_b),
    .in_last   (in_last),
    .in_ready  (in_ready_b),
    .out_best1 (out_best1_b),
    .out_best2 (out_best2_b),
    .out_idx1  (out_idx1_b),
    .out_idx2  (out_idx2_b),
    .out_count (out_count_b),
    .out_has2  (out_has2_b),
    .out_ovf   (out_ovf_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int b1, input int i1, input int b2,
                       input int i2, input int cnt, input int h2, input int ov);
    chk({tag, "/best1"}, 32'(out_best1_a), 32'(b1));
    chk({tag, "/idx1"},  32'(out_idx1_a),  32'(i1));
    chk({tag, "/best2"}, 32'(out_best2_a), 32'(b2));
    chk({tag, "/idx2"},  32'(out_idx2_a),  32'(i2));
    chk({tag, "/count"}, 32'(out_count_a), 32'(cnt));
    chk({tag, "/has2"},  32'(out_has2_a),  32'(h2));
    chk({tag, "/ovf"},   32'(out_ovf_a),   32'(ov));
  endtask

  task automatic hs_a(input string tag, input int rdy, input int vld);
    chk({tag, "/in_ready"},  32'(in_ready_a),  32'(rdy));
    chk({tag, "/out_valid"}, 32'(out_valid_a), 32'(vld));
  endtask

  task automatic beat_a(input logic [W-1:0] d, input logic last);
    in_valid_a = 1'b1;
    in_data    = d;
    in_last    = last;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_last    = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    mode       = 1'b0;
    in_data    = '0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    in_last    = 1'b0;
    out_ready  = 1'b0;
    #12;
    hs_a("reset", 1, 0);
    chk_a("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset_b/in_ready",  32'(in_ready_b),  32'd1);
    chk("reset_b/out_valid", 32'(out_valid_b), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Largest-first with a tie; mode flipped mid-frame must not matter
    mode = 1'b0;
    beat_a(4'd3, 1'b0);
    mode = 1'b1;
    beat_a(4'd9, 1'b0);
    beat_a(4'd5, 1'b0);
    beat_a(4'd9, 1'b0);
    beat_a(4'd1, 1'b1);
    hs_a("max_frame", 0, 1);
    chk_a("max_frame", 9, 1, 9, 3, 5, 1, 0);
    release_result();
    hs_a("max_release", 1, 0);
    chk_a("max_release", 0, 0, 0, 0, 0, 0, 0);

    // Smallest-first
    mode = 1'b1;
    beat_a(4'd7, 1'b0);
    beat_a(4'd2, 1'b0);
    beat_a(4'd2, 1'b0);
    beat_a(4'd0, 1'b1);
    hs_a("min_frame", 0, 1);
    chk_a("min_frame", 0, 3, 2, 1, 4, 1, 0);
    release_result();

    // Single-beat frame; result one cycle after the beat
    mode       = 1'b0;
    in_valid_a = 1'b1;
    in_data    = 4'd6;
    in_last    = 1'b1;
    chk("single/pre_valid", 32'(out_valid_a), 32'd0);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_last    = 1'b0;
    hs_a("single", 0, 1);
    chk_a("single", 6, 0, 0, 0, 1, 0, 0);
    release_result();

    // Back-pressure in HOLD while a new beat waits on in_valid
    beat_a(4'd5, 1'b0);
    beat_a(4'd3, 1'b1);
    in_valid_a = 1'b1;
    in_data    = 4'd15;
    in_last    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      hs_a("stall", 0, 1);
      chk_a("stall", 5, 0, 3, 1, 2, 1, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    hs_a("stall_release", 1, 0);
    chk("stall_release/count", 32'(out_count_a), 32'd0);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_last    = 1'b0;
    hs_a("stall_next", 0, 1);
    chk_a("stall_next", 15, 0, 0, 0, 1, 0, 0);
    release_result();

    // Count saturation on the narrow instance
    mode = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid_b = 1'b1;
      in_data    = W'(i);
      in_last    = (i == 6);
      @(posedge clk); #1;
    end
    in_valid_b = 1'b0;
    in_last    = 1'b0;
    chk("sat/out_valid", 32'(out_valid_b), 32'd1);
    chk("sat/count",     32'(out_count_b), 32'd3);
    chk("sat/ovf",       32'(out_ovf_b),   32'd1);
    chk("sat/best1",     32'(out_best1_b), 32'd6);
    chk("sat/idx1",      32'(out_idx1_b),  32'd3);
    chk("sat/best2",     32'(out_best2_b), 32'd5);
    chk("sat/idx2",      32'(out_idx2_b),  32'd3);
    chk("sat/has2",      32'(out_has2_b),  32'd1);
    chk("sat/a_idle",    32'(out_count_a), 32'd0);
    release_result();
    chk("sat_release/count", 32'(out_count_b), 32'd0);
    chk("sat_release/ovf",   32'(out_ovf_b),   32'd0);

    // Reset mid-frame discards the partial result
    beat_a(4'd7, 1'b0);
    beat_a(4'd2, 1'b0);
    chk("prerst/count", 32'(out_count_a), 32'd2);
    rst = 1'b1;
    #2;
    hs_a("midrst", 1, 0);
    chk_a("midrst", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    beat_a(4'd4, 1'b0);
    beat_a(4'd8, 1'b1);
    hs_a("postrst", 0, 1);
    chk_a("postrst", 8, 1, 4, 0, 2, 1, 0);
    release_result();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_min_stream.md
MAX_MIN_STREAM -- requirements
Module: max_min_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning sample width in bits (>=1).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the index and count fields (>=1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port mode, input, 1 bit: 0 ranks largest first, 1 ranks smallest first; sampled on each frame's first accepted beat.
REQ-006 SHALL have port in_data, input, WIDTH bits: unsigned sample.
REQ-007 SHALL have ports in_valid (input, 1), in_last (input, 1) and in_ready (output, 1): sample handshake; in_last marks the frame's final beat.
REQ-008 SHALL have ports out_best1 and out_best2 (output, WIDTH each): the best and second-best values of the frame.
REQ-009 SHALL have ports out_idx1 and out_idx2 (output, CNT_W each): the zero-based beat index of each result.
REQ-010 SHALL have port out_count, output, CNT_W bits: number of beats in the frame, saturating.
REQ-011 SHALL have ports out_has2 (output, 1) and out_ovf (output, 1): second result is valid; count saturated.
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.

Function
REQ-013 SHALL have exactly two states: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-014 SHALL accept a beat in ACC whenever in_valid=1; a beat is a cycle with in_valid&in_ready.
REQ-015 SHALL treat a candidate as "better" when it is strictly greater (mode 0) or strictly smaller (mode 1).
REQ-016 SHALL load the first beat of a frame into slot 1, with idx1=0 and has2=0.
REQ-017 SHALL, on each later beat that is better than slot 1, move slot 1 into slot 2, load the beat into slot 1, and set has2=1.
REQ-018 SHALL otherwise load the beat into slot 2 when has2=0 or the beat is better than slot 2; on a tie, the earlier beat keeps its slot.
REQ-019 SHALL give the i-th beat the index min(i, 2^CNT_W-1); count SHALL saturate at 2^CNT_W-1 and set ovf, while comparison continues.
REQ-020 SHALL go from ACC to HOLD on the cycle after the accepted in_last beat, with that beat already included (latency 1 cycle).
REQ-021 SHALL hold all out_* fields stable in HOLD and go back to ACC on the cycle after out_valid&out_ready, with the trackers cleared.
REQ-022 SHALL drive out_best2=0 and out_idx2=0 when has2=0.
REQ-023 SHALL treat a single-beat frame (in_last on the first beat) as valid: best1=sample, has2=0, count=1.
REQ-024 SHALL hold mode for the whole frame; a mode change mid-frame SHALL take effect only at the next frame.
REQ-025 SHALL ignore in_valid in HOLD, since no beat is accepted there.
REQ-026 SHALL NOT accept a new beat in the cycle out_ready is sampled high; the next frame starts in the following ACC cycle.

Reset
REQ-027 SHALL, while rst=1, force state ACC, and in_ready=1, out_valid=0, and every out_* field, has2, ovf, count and the latched mode to 0.
REQ-028 SHALL, on rst asserted mid-frame or in HOLD, discard the partial or pending result; the first beat after release starts a new frame.

Structure
REQ-029 SHALL define the state enum (ACC, HOLD) and the mode constants (MODE_MAX=0, MODE_MIN=1) in a shared package, max_min_pkg.
REQ-030 SHALL instantiate one sub-module, max_min_better (inputs: mode, cand, ref; output: better), twice: once against slot 1 and once against slot 2.

Verification
REQ-031 SHALL check: mode 0, frame 3,9,5,9,1 -> best1=9 idx1=1, best2=9 idx2=3, count=5, has2=1.
REQ-032 SHALL check: mode 1, frame 7,2,2,0 -> best1=0 idx1=3, best2=2 idx2=1, count=4.
REQ-033 SHALL check: single beat 6 with in_last -> best1=6, has2=0, best2=0, count=1, out_valid 1 cycle after the beat.
REQ-034 SHALL check: out_ready held low 5 cycles in HOLD with in_valid=1 -> outputs stable, in_ready=0, no beat lost; release resumes ACC.
REQ-035 SHALL check: CNT_W=2, frame of 6 beats 1..6, mode 0 -> count=3, ovf=1, best1=6 idx1=3, best2=5 idx2=3.
REQ-036 SHALL check: rst pulsed after beat 2 of a frame -> all outputs 0; the next frame 4,8 gives best1=8, best2=4.
